// File: rtl/traffic_monitor.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | traffic_monitor : passive phase/timing checker for the 2-way lights       |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module traffic_monitor #(
  parameter int GREEN_CYC  = 6,
  parameter int YELLOW_CYC = 2,
  parameter int ALLRED_CYC = 2,
  parameter int CNT_W      = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] traffic_A,
  input  logic [2:0] traffic_B,
  input  logic       clear_err,
  output logic       locked,
  output logic [2:0] phase,
  output logic       err_encoding,
  output logic       err_conflict,
  output logic       err_sequence,
  output logic       err_timing,
  output logic       err_pulse,
  output logic [7:0] cycle_cnt
);

  localparam logic [2:0] c_SYNC  = 3'd0;
  localparam logic [2:0] c_A_GRN = 3'd1;
  localparam logic [2:0] c_A_YEL = 3'd2;
  localparam logic [2:0] c_RED1  = 3'd3;
  localparam logic [2:0] c_B_GRN = 3'd4;
  localparam logic [2:0] c_B_YEL = 3'd5;
  localparam logic [2:0] c_RED2  = 3'd6;

  localparam logic [2:0] c_LT_GRN = 3'b001;
  localparam logic [2:0] c_LT_YEL = 3'b010;
  localparam logic [2:0] c_LT_RED = 3'b100;

  localparam logic [CNT_W-1:0] c_GREEN  = CNT_W'(GREEN_CYC);
  localparam logic [CNT_W-1:0] c_YELLOW = CNT_W'(YELLOW_CYC);
  localparam logic [CNT_W-1:0] c_ALLRED = CNT_W'(ALLRED_CYC);
  localparam logic [CNT_W-1:0] c_ONE    = CNT_W'(1);

  logic [2:0]       r_phase;
  logic             r_locked;
  logic [CNT_W-1:0] r_dwell;
  logic             r_prev_agrn;
  logic [7:0]       r_cycle;
  logic             r_err_enc;
  logic             r_err_conf;
  logic             r_err_seq;
  logic             r_err_tim;
  logic             r_pulse;

  logic             w_onehot_a;
  logic             w_onehot_b;
  logic             w_v_enc;
  logic             w_v_conf;
  logic             w_v_seq;
  logic             w_v_tim;
  logic [2:0]       w_pat;
  logic [2:0]       w_cur_pat;
  logic [2:0]       w_succ_pat;
  logic [2:0]       w_succ_phase;
  logic [CNT_W-1:0] w_req;
  logic             w_is_agrn;
  logic             w_sync_hit;

  logic [2:0]       w_nxt_phase;
  logic             w_nxt_locked;
  logic [CNT_W-1:0] w_nxt_dwell;
  logic [7:0]       w_nxt_cycle;
  logic             w_nxt_err_enc;
  logic             w_nxt_err_conf;
  logic             w_nxt_err_seq;
  logic             w_nxt_err_tim;
  logic             w_nxt_pulse;

  assign w_onehot_a = (traffic_A == c_LT_GRN) || (traffic_A == c_LT_YEL) || (traffic_A == c_LT_RED);
  assign w_onehot_b = (traffic_B == c_LT_GRN) || (traffic_B == c_LT_YEL) || (traffic_B == c_LT_RED);
  assign w_v_enc    = ~(w_onehot_a & w_onehot_b);
  assign w_v_conf   = ~w_v_enc & (traffic_A != c_LT_RED) & (traffic_B != c_LT_RED);

  // Both all-red phases decode to the RED1 code; the phase history tells them apart.
  always_comb begin
    w_pat = c_SYNC;
    case ({traffic_A, traffic_B})
      {c_LT_GRN, c_LT_RED}: w_pat = c_A_GRN;
      {c_LT_YEL, c_LT_RED}: w_pat = c_A_YEL;
      {c_LT_RED, c_LT_RED}: w_pat = c_RED1;
      {c_LT_RED, c_LT_GRN}: w_pat = c_B_GRN;
      {c_LT_RED, c_LT_YEL}: w_pat = c_B_YEL;
      default:              w_pat = c_SYNC;
    endcase
  end

  assign w_is_agrn  = (w_pat == c_A_GRN);
  assign w_sync_hit = w_is_agrn & ~r_prev_agrn;
  assign w_cur_pat  = (r_phase == c_RED2) ? c_RED1 : r_phase;

  always_comb begin
    w_req        = '0;
    w_succ_phase = c_SYNC;
    w_succ_pat   = c_SYNC;
    case (r_phase)
      c_A_GRN: begin w_req = c_GREEN;  w_succ_phase = c_A_YEL; w_succ_pat = c_A_YEL; end
      c_A_YEL: begin w_req = c_YELLOW; w_succ_phase = c_RED1;  w_succ_pat = c_RED1;  end
      c_RED1:  begin w_req = c_ALLRED; w_succ_phase = c_B_GRN; w_succ_pat = c_B_GRN; end
      c_B_GRN: begin w_req = c_GREEN;  w_succ_phase = c_B_YEL; w_succ_pat = c_B_YEL; end
      c_B_YEL: begin w_req = c_YELLOW; w_succ_phase = c_RED2;  w_succ_pat = c_RED1;  end
      c_RED2:  begin w_req = c_ALLRED; w_succ_phase = c_A_GRN; w_succ_pat = c_A_GRN; end
      default: begin w_req = '0;       w_succ_phase = c_SYNC;  w_succ_pat = c_SYNC;  end
    endcase
  end

  // Next-state: phase tracking, dwell counting, sequence and timing checks.
  always_comb begin
    w_nxt_phase  = r_phase;
    w_nxt_locked = r_locked;
    w_nxt_dwell  = r_dwell;
    w_nxt_cycle  = r_cycle;
    w_v_seq      = 1'b0;
    w_v_tim      = 1'b0;
    if (w_v_enc || w_v_conf) begin
      w_nxt_phase  = c_SYNC;
      w_nxt_locked = 1'b0;
      w_nxt_dwell  = '0;
    end else if (!r_locked) begin
      if (w_sync_hit) begin
        w_nxt_phase  = c_A_GRN;
        w_nxt_locked = 1'b1;
        w_nxt_dwell  = c_ONE;
      end
    end else if (w_pat == w_cur_pat) begin
      if (r_dwell != '1) begin
        w_nxt_dwell = r_dwell + c_ONE;
      end
      // Dwell reaches req+1 exactly once per phase, so this flags only once.
      if (r_dwell == w_req) begin
        w_v_tim = 1'b1;
      end
    end else if (w_pat == w_succ_pat) begin
      if (r_dwell < w_req) begin
        w_v_tim = 1'b1;
      end
      if ((r_phase == c_RED2) && (r_dwell == c_ALLRED)) begin
        w_nxt_cycle = r_cycle + 8'd1;
      end
      w_nxt_phase = w_succ_phase;
      w_nxt_dwell = c_ONE;
    end else begin
      w_v_seq = 1'b1;
      if (w_sync_hit) begin
        w_nxt_phase  = c_A_GRN;
        w_nxt_locked = 1'b1;
        w_nxt_dwell  = c_ONE;
      end else begin
        w_nxt_phase  = c_SYNC;
        w_nxt_locked = 1'b0;
        w_nxt_dwell  = '0;
      end
    end
  end

  // Outputs: a violation on the same edge as clear_err keeps its flag set.
  always_comb begin
    w_nxt_err_enc  = (r_err_enc  & ~clear_err) | w_v_enc;
    w_nxt_err_conf = (r_err_conf & ~clear_err) | w_v_conf;
    w_nxt_err_seq  = (r_err_seq  & ~clear_err) | w_v_seq;
    w_nxt_err_tim  = (r_err_tim  & ~clear_err) | w_v_tim;
    w_nxt_pulse    = w_v_enc | w_v_conf | w_v_seq | w_v_tim;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_phase     <= c_SYNC;
      r_locked    <= 1'b0;
      r_dwell     <= '0;
      r_prev_agrn <= 1'b0;
      r_cycle     <= 8'd0;
      r_err_enc   <= 1'b0;
      r_err_conf  <= 1'b0;
      r_err_seq   <= 1'b0;
      r_err_tim   <= 1'b0;
      r_pulse     <= 1'b0;
    end else begin
      r_phase     <= w_nxt_phase;
      r_locked    <= w_nxt_locked;
      r_dwell     <= w_nxt_dwell;
      r_prev_agrn <= w_is_agrn;
      r_cycle     <= w_nxt_cycle;
      r_err_enc   <= w_nxt_err_enc;
      r_err_conf  <= w_nxt_err_conf;
      r_err_seq   <= w_nxt_err_seq;
      r_err_tim   <= w_nxt_err_tim;
      r_pulse     <= w_nxt_pulse;
    end
  end

  assign locked       = r_locked;
  assign phase        = r_phase;
  assign err_encoding = r_err_enc;
  assign err_conflict = r_err_conf;
  assign err_sequence = r_err_seq;
  assign err_timing   = r_err_tim;
  assign err_pulse    = r_pulse;
  assign cycle_cnt    = r_cycle;

endmodule
`default_nettype wire
